// File: rtl/serial_arith_pkg.sv
// Shared definitions for bit-serial arithmetic blocks.
// Holds the controller state encoding and the default operand width, so a
// serial subtractor and a future serial adder stay consistent.
package serial_arith_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor slice (combinational).
// Ports: a, b   - operand bits (computes a - b - bin)
//        bin    - borrow in
//        d      - difference bit
//        bout   - borrow out
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_subtractor_4bit.sv
// Bit-serial subtractor: Diff = A - B - Bin (mod 2^WIDTH), Bout = borrow-out.
// One bit per clock, LSB first, through a single full_subtractor slice.
// Ports: clk, rst (async, active-high)
//        start          - begin an operation (sampled only in IDLE)
//        A, B, Bin      - operands, captured on the accepting edge
//        busy           - high while bits are being processed
//        done           - one-cycle completion pulse
//        Diff, Bout     - registered result, held until the next completion
module serial_subtractor_4bit
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] a_sr, b_sr;
  // Only WIDTH-1 bits are stored; the final bit goes straight into Diff.
  logic [WIDTH-2:0] res;
  logic [WIDTH-1:0] res_next;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             d, bnext, last;

  full_subtractor u_fs (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (borrow),
    .d    (d),
    .bout (bnext)
  );

  // New bit enters from the MSB side; after WIDTH bits res_next is the result.
  assign res_next = {d, res};
  assign last     = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = SHIFT;
      SHIFT:   if (last)  state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res    <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      Diff   <= '0;
      Bout   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      // Status flags are registered copies of the upcoming state.
      busy <= (state_n == SHIFT);
      done <= (state_n == DONE);
      case (state)
        IDLE: if (start) begin
          a_sr   <= A;
          b_sr   <= B;
          borrow <= Bin;
          cnt    <= '0;
        end
        SHIFT: begin
          a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
          borrow <= bnext;
          res    <= res_next[WIDTH-1:1];
          cnt    <= cnt + CW'(1);
          if (last) begin
            Diff <= res_next;
            Bout <= bnext;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_4bit.sv
// Self-checking bench for serial_subtractor_4bit: directed corner vectors,
// randomized operands against an integer-arithmetic reference, start-line
// stability, back-to-back spacing and mid-operation asynchronous reset.
module tb_serial_subtractor_4bit;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A = '0, B = '0;
  logic         Bin = 1'b0;
  logic         busy, done, Bout;
  logic [W-1:0] Diff;

  int n_chk = 0;
  int n_pass = 0;

  serial_subtractor_4bit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Bin(Bin),
    .busy(busy), .done(done), .Diff(Diff), .Bout(Bout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: plain integer subtraction, borrow when the result goes negative.
  function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    int r;
    logic [W-1:0] dv;
    r  = int'(a) - int'(b) - int'(bi);
    dv = W'(r & ((1 << W) - 1));
    return {(r < 0), dv};
  endfunction

  // Pulse start from IDLE and follow the operation to completion.
  // Operands are scrambled right after acceptance to confirm they were captured.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    int edges, bcyc;
    logic [W-1:0] pd;
    logic pb, held;
    logic [W:0] e;
    e = ref_sub(a, b, bi);
    @(negedge clk);
    A = a; B = b; Bin = bi; start = 1'b1;
    pd = Diff; pb = Bout;
    edges = 0; bcyc = 0; held = 1'b1;
    do begin
      @(posedge clk); #1;
      edges++;
      if (edges == 1) begin
        start = 1'b0;
        A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
      end
      if (busy) bcyc++;
      if (busy && done) held = 1'b0;
      if (!done && (Diff !== pd || Bout !== pb)) held = 1'b0;
    end while (!done && edges < 20);
    chk({tag, "_lat"}, edges, W + 1);
    chk({tag, "_busy"}, bcyc, W);
    chk({tag, "_hold"}, held, 1);
    chk({tag, "_diff"}, Diff, e[W-1:0]);
    chk({tag, "_bout"}, Bout, e[W]);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, {busy, done}, 0);
  endtask

  initial begin
    int cnt_done, last_t, t;
    logic [W:0] e;

    // Reset state
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", Diff, 0);
    chk("rst_bout", Bout, 0);
    @(negedge clk); rst = 1'b0;

    // Directed corner vectors
    run_op("zero", 4'b0000, 4'b0000, 1'b0);
    run_op("v5m3", 4'b0101, 4'b0011, 1'b0);
    run_op("v3m5", 4'b0011, 4'b0101, 1'b1);
    run_op("v0mF", 4'b0000, 4'b1111, 1'b1);
    run_op("vFm0", 4'b1111, 4'b0000, 1'b0);

    // Randomized operands
    for (int i = 0; i < 20; i++)
      run_op("rnd", W'($urandom), W'($urandom), 1'($urandom));

    // Operand change and start pulse during SHIFT are ignored
    @(negedge clk); A = 4'b0101; B = 4'b0011; Bin = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;          // accepting edge
    @(posedge clk);                           // SHIFT cycle 2 begins
    @(negedge clk); A = 4'b1111; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cnt_done = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (done) begin
        cnt_done++;
        chk("ign_diff", Diff, 4'b0010);
        chk("ign_bout", Bout, 0);
      end
    end
    chk("ign_ndone", cnt_done, 1);

    // start held high: back-to-back operations every W+2 cycles
    @(negedge clk); A = 4'b1001; B = 4'b0100; Bin = 1'b0; start = 1'b1;
    e = ref_sub(4'b1001, 4'b0100, 1'b0);
    cnt_done = 0; last_t = -1;
    for (t = 0; t < 40; t++) begin
      @(posedge clk); #1;
      if (done) begin
        cnt_done++;
        chk("b2b_diff", Diff, e[W-1:0]);
        if (last_t >= 0) chk("b2b_gap", t - last_t, W + 2);
        last_t = t;
      end
    end
    chk("b2b_cnt_ok", (cnt_done >= 5), 1);
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < W + 3; i++) @(posedge clk);
    #1 chk("b2b_idle", {busy, done}, 0);

    // Asynchronous reset mid-operation aborts cleanly
    @(negedge clk); A = 4'b1111; B = 4'b0001; Bin = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;          // accepting edge
    @(posedge clk); @(posedge clk);           // SHIFT cycle 3
    #3 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_diff", Diff, 0);
    chk("arst_bout", Bout, 0);
    @(negedge clk); @(negedge clk); rst = 1'b0;
    cnt_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done || busy) cnt_done++;
    end
    chk("arst_quiet", cnt_done, 0);
    run_op("post_rst", 4'b1000, 4'b0001, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule

// File: doc/serial_subtractor_4bit.md
SERIAL_SUBTRACTOR_4BIT -- requirements
Module: serial_subtractor_4bit

Interface
REQ-001 Parameter WIDTH, default 4, operand and result width in bits; SHALL be at least 2.
REQ-002 Port clk, input, 1, single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1; reset is asynchronous and active-high.
REQ-004 Port start, input, 1, request to begin a subtraction; SHALL be sampled only in IDLE.
REQ-005 Port A, input, WIDTH, minuend; SHALL be captured on the edge that accepts start.
REQ-006 Port B, input, WIDTH, subtrahend; SHALL be captured on the edge that accepts start.
REQ-007 Port Bin, input, 1, borrow-in; SHALL be captured on the edge that accepts start.
REQ-008 Port busy, output, 1, high while an operation is in progress (state SHIFT).
REQ-009 Port done, output, 1, single-cycle completion pulse (state DONE).
REQ-010 Port Diff, output, WIDTH, registered result of A - B - Bin, modulo 2^WIDTH.
REQ-011 Port Bout, output, 1, registered borrow-out: 1 exactly when A < B + Bin as unsigned values.

Function
REQ-012 FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-013 IDLE SHALL move to SHIFT when start=1; otherwise it SHALL stay in IDLE.
REQ-014 On acceptance, the block SHALL load A and B into internal shift registers, load Bin into the borrow flip-flop, and clear the bit counter.
REQ-015 SHIFT SHALL process one bit per cycle, LSB first, through one full-subtractor slice:
- d = a XOR b XOR borrow
- next borrow = (~a & b) | (~a & borrow) | (b & borrow)
REQ-016 Each result bit d SHALL shift into an internal result register, MSB-side entry.
REQ-017 SHIFT SHALL last exactly WIDTH cycles; after the WIDTH-th processed bit, the FSM SHALL enter DONE.
REQ-018 On the edge entering DONE, Diff SHALL load the internal result and Bout SHALL load the final borrow.
REQ-019 done SHALL be high for exactly one cycle, WIDTH+1 rising edges after the accepting edge; DONE SHALL always return to IDLE on the next edge.
REQ-020 Diff and Bout SHALL hold their values until the next completion; they SHALL NOT change during SHIFT.
REQ-021 start asserted in SHIFT or DONE SHALL be ignored: no restart, no operand recapture, no queuing.
REQ-022 Changes on A, B or Bin after acceptance SHALL NOT affect the result in progress.
REQ-023 start held high continuously SHALL give back-to-back operations, each accepted from IDLE, one every WIDTH+2 cycles.
REQ-024 The counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap within an operation.
REQ-025 busy and done SHALL be mutually exclusive and both low in IDLE.

Reset
REQ-026 When rst=1, the block SHALL immediately, without waiting for clk, force:
- state = IDLE, busy = 0, done = 0
- Diff = 0, Bout = 0
- counter, borrow flip-flop and shift registers = 0
REQ-027 Reset asserted mid-operation SHALL abort it; no done pulse and no partial result SHALL appear.
REQ-028 After rst is released, the first rising edge with start=1 SHALL be accepted normally.

Structure
REQ-029 The state encoding (IDLE/SHIFT/DONE) and the default WIDTH SHALL live in a shared package, serial_arith_pkg, reusable by a future serial adder.
REQ-030 The one-bit slice SHALL be a separate combinational sub-module, full_subtractor, with ports a, b, bin, d and bout.
REQ-031 All outputs SHALL be driven directly from flip-flops.

Verification
REQ-032 A=0000, B=0000, Bin=0, start pulse -> done after 5 edges; Diff=0000, Bout=0.
REQ-033 A=0101, B=0011, Bin=0 -> Diff=0010, Bout=0; busy high for exactly 4 cycles.
REQ-034 A=0011, B=0101, Bin=1 -> Diff=1101, Bout=1.
REQ-035 A=0000, B=1111, Bin=1 -> Diff=0000, Bout=1. A=1111, B=0000, Bin=0 -> Diff=1111, Bout=0.
REQ-036 Operand and start-line stability during an operation:
- Start 0101-0011; in cycle 2 of SHIFT, change A to 1111 and pulse start -> result still 0010, exactly one done.
- Hold start high continuously -> done spaced exactly 6 cycles apart.
REQ-037 Start 1111-0001; assert rst in cycle 3 of SHIFT (not on a clock edge) -> busy, Diff and Bout clear at once, with no done; after release, 1000-0001 -> Diff=0111, Bout=0.
